sfifo_tx_pack_256: RTL and testbench

Hardware-to-host end of the streaming FIFO channel. The block accepts variable-length 256-bit beats from the DUT side and prefixes each beat with a 64-bit header. It packs the header and payload words into 256-bit lines and writes them into the outbound line buffer. Flow control is credit based: the block owns the write pointer and the host owns the read pointer.

---
 rtl/sfifo_tx_pack_256.sv | 185 ++++++++++++++++++
 tb/tb_sfifo_tx_pack_256.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_tx_pack_256.sv
// sfifo_tx_pack_256: hardware-to-host packer for the streaming FIFO channel.
// Each accepted beat becomes a 64-bit header followed by 0..4 payload words.
// Words are staged in an 8-lane register and written out four at a time as
// 256-bit lines into the outbound line buffer, with credit-based flow control
// against the host read pointer.
//
// Ports:
//   clk, rstN        clock, asynchronous active-low reset
//   iValid/iReady    beat handshake (accepted when both high)
//   iData, iLen      payload (word k = iData[64k+:64]) and word count 0..4
//   iMark            end of message, forces a flush after this beat
//   rptr             host read pointer (MSB is the wrap bit)
//   wptr             write pointer, advances the cycle after each line write
//   bufWrEn/bufAddr/bufData  line buffer write port (lane0 = [63:0])
//   rdCnt            total accepted beats
//   errLen           sticky flag for an accepted iLen > 4
module sfifo_tx_pack_256 #(
  parameter int unsigned ADDR_W    = 15,
  parameter logic [11:0] FLUSH_DLY = 12'd256,
  parameter logic [63:0] NOP_WORD  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              iValid,
  output logic              iReady,
  input  logic [255:0]      iData,
  input  logic [3:0]        iLen,
  input  logic              iMark,
  input  logic [ADDR_W:0]   rptr,
  output logic [ADDR_W:0]   wptr,
  output logic              bufWrEn,
  output logic [ADDR_W-1:0] bufAddr,
  output logic [255:0]      bufData,
  output logic [63:0]       rdCnt,
  output logic              errLen
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e         stateQ, stateD;
  logic [3:0]     fillQ, fillD;
  logic [63:0]    lanesQ [8];
  logic [63:0]    lanesD [8];
  logic [31:0]    seqQ, seqD;
  logic [ADDR_W:0] wptrQ, wptrD;
  logic [11:0]    idleQ, idleD;
  logic [63:0]    rdCntQ, rdCntD;
  logic           errLenQ, errLenD;

  logic [ADDR_W:0] used;
  logic            canEmit;
  logic            accept;
  logic            fullEmit;
  logic            partEmit;
  logic            emit;
  logic [3:0]      lenEff;
  logic [63:0]     words [5];

  // Buffer is full exactly when the writer is one full lap ahead of the reader.
  assign used    = wptrQ - rptr;
  assign canEmit = !(used[ADDR_W] && (used[ADDR_W-1:0] == '0));

  assign iReady   = rstN && (stateQ == StRun) && (fillQ <= 4'd3);
  assign accept   = iValid && iReady;
  assign lenEff   = (iLen > 4'd4) ? 4'd4 : iLen;
  assign fullEmit = (fillQ >= 4'd4) && canEmit;
  // Padded short line, only while flushing and only once no full line remains.
  assign partEmit = (stateQ == StFlush) && (fillQ != 4'd0) && (fillQ < 4'd4) && canEmit;
  assign emit     = fullEmit || partEmit;

  always_comb begin
    words[0] = {8'hC3, 7'b0, iMark, 12'b0, lenEff, seqQ};
    for (int j = 1; j < 5; j++) begin
      words[j] = iData[64*(j-1) +: 64];
    end
  end

  // Line buffer write port.
  always_comb begin
    bufData = '0;
    if (emit) begin
      for (int k = 0; k < 4; k++) begin
        if (partEmit && (4'(k) >= fillQ)) begin
          bufData[64*k +: 64] = NOP_WORD;
        end else begin
          bufData[64*k +: 64] = lanesQ[k];
        end
      end
    end
  end

  assign bufWrEn = emit;
  assign bufAddr = wptrQ[ADDR_W-1:0];
  assign wptr    = wptrQ;
  assign rdCnt   = rdCntQ;
  assign errLen  = errLenQ;

  // Next-state: drain lanes first, then append the accepted beat above what remains.
  always_comb begin
    logic [3:0] baseFill;
    logic [3:0] off;
    baseFill = fillQ;
    off      = '0;
    for (int k = 0; k < 8; k++) begin
      lanesD[k] = lanesQ[k];
    end
    if (fullEmit) begin
      baseFill = fillQ - 4'd4;
      for (int k = 0; k < 4; k++) begin
        lanesD[k] = lanesQ[k+4];
      end
    end else if (partEmit) begin
      baseFill = 4'd0;
    end

    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        off = 4'(k) - baseFill;
        if ((4'(k) >= baseFill) && (off <= lenEff)) begin
          lanesD[k] = words[off[2:0]];
        end
      end
      fillD = baseFill + lenEff + 4'd1;
    end else begin
      fillD = baseFill;
    end

    stateD = stateQ;
    case (stateQ)
      StRun: begin
        if (accept && iMark) begin
          stateD = StFlush;
        end else if ((idleQ >= FLUSH_DLY) && (fillQ != 4'd0) && (fillQ < 4'd4)) begin
          stateD = StFlush;
        end
      end
      StFlush: begin
        if (partEmit || (fillQ == 4'd0)) begin
          stateD = StRun;
        end
      end
      default: stateD = StRun;
    endcase

    if (accept || emit) begin
      idleD = '0;
    end else if (idleQ != 12'hFFF) begin
      idleD = idleQ + 12'd1;
    end else begin
      idleD = idleQ;
    end

    seqD    = seqQ + 32'(accept);
    rdCntD  = rdCntQ + 64'(accept);
    errLenD = errLenQ || (accept && (iLen > 4'd4));
    wptrD   = wptrQ + {{ADDR_W{1'b0}}, emit};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ  <= StRun;
      fillQ   <= '0;
      seqQ    <= '0;
      wptrQ   <= '0;
      idleQ   <= '0;
      rdCntQ  <= '0;
      errLenQ <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        lanesQ[k] <= '0;
      end
    end else begin
      stateQ  <= stateD;
      fillQ   <= fillD;
      seqQ    <= seqD;
      wptrQ   <= wptrD;
      idleQ   <= idleD;
      rdCntQ  <= rdCntD;
      errLenQ <= errLenD;
      for (int k = 0; k < 8; k++) begin
        lanesQ[k] <= lanesD[k];
      end
    end
  end

endmodule

// File: tb/tb_sfifo_tx_pack_256.sv
// Self-checking bench for sfifo_tx_pack_256. A word-queue model rebuilds the
// expected line stream from accepted beats; directed cases cover reset, mark
// flush, idle flush, buffer-full back-pressure, oversize length and mid-packet
// reset, followed by a randomized run with a lagging host.
module tb_sfifo_tx_pack_256;

  localparam int unsigned AW  = 2;
  localparam int          DLY = 40;
  localparam logic [63:0] NOP = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          iValid = 1'b0;
  logic          iReady;
  logic [255:0]  iData = '0;
  logic [3:0]    iLen = '0;
  logic          iMark = 1'b0;
  logic [AW:0]   rptr = '0;
  logic [AW:0]   wptr;
  logic          bufWrEn;
  logic [AW-1:0] bufAddr;
  logic [255:0]  bufData;
  logic [63:0]   rdCnt;
  logic          errLen;

  sfifo_tx_pack_256 #(
    .ADDR_W   (AW),
    .FLUSH_DLY(12'(DLY)),
    .NOP_WORD (NOP)
  ) dut (
    .clk    (clk),
    .rstN   (rstN),
    .iValid (iValid),
    .iReady (iReady),
    .iData  (iData),
    .iLen   (iLen),
    .iMark  (iMark),
    .rptr   (rptr),
    .wptr   (wptr),
    .bufWrEn(bufWrEn),
    .bufAddr(bufAddr),
    .bufData(bufData),
    .rdCnt  (rdCnt),
    .errLen (errLen)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  // Reference model state.
  logic [63:0] q[$];
  logic [31:0] acceptCnt = '0;
  logic [AW:0] wrCnt = '0;
  logic        errExp = 1'b0;
  logic        idleFlushOk = 1'b0;
  int          lastAccCyc = 0;
  int          lastWrCyc = 0;
  logic        hostAuto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkHdr(input logic [31:0] seq, input logic [3:0] len,
                                        input logic mark);
    return {8'hC3, 7'b0, mark, 12'b0, len, seq};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic clearModel();
    q.delete();
    acceptCnt = '0;
    wrCnt = '0;
    errExp = 1'b0;
  endtask

  // Model update, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin : monitor
    logic [255:0] expLine;
    logic [AW:0]  usedM;
    int           lenM;
    if (rstN) begin
      if (bufWrEn) begin
        usedM = wrCnt - rptr;
        checkEq("space_ok", 256'(usedM < (AW+1)'(1 << AW)), 256'(1));
        if (q.size() < 4) begin
          if (!(idleFlushOk && q.size() > 0)) checkEq("underrun", 256'(q.size()), 256'(4));
          while (q.size() < 4) q.push_back(NOP);
        end
        for (int i = 0; i < 4; i++) expLine[64*i +: 64] = q[i];
        for (int i = 0; i < 4; i++) void'(q.pop_front());
        checkEq("line", bufData, expLine);
        checkEq("addr", 256'(bufAddr), 256'(wrCnt[AW-1:0]));
        wrCnt = wrCnt + 1'b1;
        lastWrCyc = cyc;
      end
      if (iValid && iReady) begin
        lenM = (iLen > 4) ? 4 : int'(iLen);
        q.push_back(mkHdr(acceptCnt, 4'(lenM), iMark));
        for (int j = 0; j < lenM; j++) q.push_back(iData[64*j +: 64]);
        if (iLen > 4) errExp = 1'b1;
        if (iMark) while (q.size() % 4 != 0) q.push_back(NOP);
        acceptCnt = acceptCnt + 1;
        lastAccCyc = cyc;
      end
    end
  end

  // Host: consumes written lines with random lag and occasional stalls.
  initial begin : host
    int stall;
    stall = 0;
    forever begin
      @(posedge clk);
      #1;
      if (hostAuto) begin
        if (stall > 0) stall--;
        else if ($urandom_range(0, 31) == 0) stall = $urandom_range(5, 20);
        else if ((rptr != wrCnt) && ($urandom_range(0, 3) != 0)) rptr = rptr + 1'b1;
      end
    end
  end

  task automatic doReset();
    rstN = 1'b0;
    iValid = 1'b0;
    rptr = '0;
    clearModel();
    #1;
    checkEq("rst_iready", 256'(iReady), 256'(0));
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkEq("post_rst_iready", 256'(iReady), 256'(1));
  endtask

  task automatic sendBeat(input logic [255:0] d, input logic [3:0] len, input logic mark);
    int n;
    @(posedge clk);
    #1;
    iValid = 1'b1;
    iData = d;
    iLen = len;
    iMark = mark;
    n = 0;
    @(negedge clk);
    while (!iReady && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!iReady) checkEq("accept_timeout", 256'(iReady), 256'(1));
    @(posedge clk);
    #1 iValid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int n;
    logic [AW:0] startCnt;
    int d;

    // 1: four 4-word beats fill the whole 4-line buffer.
    hostAuto = 1'b0;
    doReset();
    checkEq("rst_wptr", 256'(wptr), 256'(0));
    checkEq("rst_rdcnt", 256'(rdCnt), 256'(0));
    for (int i = 0; i < 4; i++) sendBeat(rand256(), 4'd3, 1'b0);
    waitCycles(5);
    checkEq("t1_lines", 256'(wrCnt), 256'(4));
    checkEq("t1_wptr", 256'(wptr), 256'(4));
    checkEq("t1_rdcnt", 256'(rdCnt), 256'(4));
    checkEq("t1_full_iready", 256'(iReady), 256'(1));

    // 2: marked single-word beat gives one padded line quickly.
    doReset();
    sendBeat(rand256(), 4'd1, 1'b1);
    n = 0;
    while (wptr != 1 && n < 3) begin
      n++;
      @(negedge clk);
    end
    checkEq("t2_wptr", 256'(wptr), 256'(1));
    checkEq("t2_drained", 256'(q.size()), 256'(0));

    // 3: unmarked short beat is flushed only after the idle delay.
    idleFlushOk = 1'b1;
    startCnt = wrCnt;
    sendBeat(rand256(), 4'd2, 1'b0);
    n = 0;
    while (wrCnt == startCnt && n < DLY + 20) begin
      n++;
      @(negedge clk);
    end
    checkEq("t3_flush_seen", 256'(wrCnt), 256'(startCnt + 1'b1));
    d = lastWrCyc - lastAccCyc;
    checkEq("t3_not_early", 256'(d >= DLY), 256'(1));
    checkEq("t3_not_late", 256'(d <= DLY + 3), 256'(1));
    idleFlushOk = 1'b0;
    checkEq("t3_wptr", 256'(wptr), 256'(2));

    // 4: buffer full back-pressure, then release and wrap.
    doReset();
    for (int i = 0; i < 5; i++) sendBeat(rand256(), 4'd3, 1'b0);
    fork
      sendBeat(rand256(), 4'd3, 1'b0);
      begin
        waitCycles(20);
        checkEq("t4_writes_held", 256'(wrCnt), 256'(4));
        checkEq("t4_wptr_full", 256'(wptr), 256'(4));
        checkEq("t4_iready_low", 256'(iReady), 256'(0));
        @(posedge clk);
        #1 rptr = 3'd2;
      end
    join
    waitCycles(6);
    checkEq("t4_writes", 256'(wrCnt), 256'(6));
    checkEq("t4_wptr_wrap", 256'(wptr), 256'(3'b110));

    // 5: oversize length clamps to four words and sets sticky errLen.
    hostAuto = 1'b1;
    doReset();
    sendBeat(rand256(), 4'd7, 1'b0);
    waitCycles(2);
    checkEq("t5_errlen", 256'(errLen), 256'(1));
    sendBeat(rand256(), 4'd2, 1'b1);
    waitCycles(10);
    checkEq("t5_errlen_sticky", 256'(errLen), 256'(errExp));
    checkEq("t5_rdcnt", 256'(rdCnt), 256'(acceptCnt));
    checkEq("t5_drained", 256'(q.size()), 256'(0));

    // 6: reset with three words staged discards them.
    sendBeat(rand256(), 4'd2, 1'b0);
    @(posedge clk);
    #3 rstN = 1'b0;
    clearModel();
    rptr = '0;
    #1;
    checkEq("t6_iready", 256'(iReady), 256'(0));
    checkEq("t6_wptr", 256'(wptr), 256'(0));
    checkEq("t6_wren", 256'(bufWrEn), 256'(0));
    checkEq("t6_addr", 256'(bufAddr), 256'(0));
    checkEq("t6_data", bufData, 256'(0));
    checkEq("t6_rdcnt", 256'(rdCnt), 256'(0));
    checkEq("t6_errlen", 256'(errLen), 256'(0));
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    sendBeat(rand256(), 4'd0, 1'b1);
    waitCycles(6);
    checkEq("t6_restart_wptr", 256'(wptr), 256'(1));
    checkEq("t6_restart_rdcnt", 256'(rdCnt), 256'(1));

    // Randomized run with a lagging, stalling host.
    doReset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] len;
      len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                         : 4'($urandom_range(0, 4));
      sendBeat(rand256(), len, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    sendBeat(rand256(), 4'($urandom_range(0, 4)), 1'b1);
    n = 0;
    while ((q.size() != 0 || wptr != wrCnt) && n < 500) begin
      n++;
      @(negedge clk);
    end
    checkEq("rnd_drained", 256'(q.size()), 256'(0));
    checkEq("rnd_wptr", 256'(wptr), 256'(wrCnt));
    checkEq("rnd_rdcnt", 256'(rdCnt), 256'(acceptCnt));
    checkEq("rnd_errlen", 256'(errLen), 256'(errExp));

    hostAuto = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
